// File: rtl/pwm_cfg_sequencer_if.sv
// Host-side configuration bus of the PWM config sequencer: register writes plus
// the commit handshake that moves shadow config into the running counter.
interface pwm_cfg_sequencer_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;
    logic        commit_req;
    logic        commit_done;
    logic        busy;

    modport master (
        output wr_valid, wr_addr, wr_data, commit_req,
        input  wr_ready, commit_done, busy
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, commit_req,
        output wr_ready, commit_done, busy
    );
endinterface

// File: rtl/pwm_cfg_sequencer.sv
// PWM configuration sequencer: shadow registers written over the config bus are
// applied to the counter only at a counter safe point, with a registered count reset.
module pwm_cfg_sequencer (
    input  logic                  clk,
    input  logic                  rst,
    pwm_cfg_sequencer_if.slave    cfg,
    input  logic [15:0]           count_val,
    output logic [15:0]           period,
    output logic [7:0]            prescale,
    output logic                  en,
    output logic                  upnotdown,
    output logic                  count_reset
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_APPLY = 2'd2
    } state_t;

    localparam logic [15:0] RST_PERIOD   = 16'h00FF;
    localparam logic [7:0]  RST_PRESCALE = 8'h00;

    state_t      state_r;
    logic [15:0] sh_period_r;
    logic [7:0]  sh_prescale_r;
    logic        sh_en_r;
    logic        sh_upnotdown_r;
    logic [15:0] period_r;
    logic [7:0]  prescale_r;
    logic        en_r;
    logic        upnotdown_r;
    logic        count_reset_r;
    logic        commit_done_r;
    logic        idle_s;
    logic        wr_acc_s;
    logic        safe_s;

    assign idle_s   = (state_r == ST_IDLE);
    assign wr_acc_s = cfg.wr_valid & idle_s;

    // Safe point is judged on what the counter is running now, never on the shadow copy
    assign safe_s = (~en_r)
                  | (upnotdown_r  & (count_val == period_r))
                  | (~upnotdown_r & (count_val == 16'h0000));

    assign cfg.wr_ready    = idle_s;
    assign cfg.busy        = ~idle_s;
    assign cfg.commit_done = commit_done_r;
    assign period          = period_r;
    assign prescale        = prescale_r;
    assign en              = en_r;
    assign upnotdown       = upnotdown_r;
    assign count_reset     = count_reset_r;

    // Commit FSM together with shadow/active config and the one-cycle pulse outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            sh_period_r    <= RST_PERIOD;
            sh_prescale_r  <= RST_PRESCALE;
            sh_en_r        <= 1'b0;
            sh_upnotdown_r <= 1'b1;
            period_r       <= RST_PERIOD;
            prescale_r     <= RST_PRESCALE;
            en_r           <= 1'b0;
            upnotdown_r    <= 1'b1;
            count_reset_r  <= 1'b0;
            commit_done_r  <= 1'b0;
        end else begin
            count_reset_r <= 1'b0;
            commit_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (wr_acc_s) begin
                        case (cfg.wr_addr)
                            2'd0: sh_period_r   <= cfg.wr_data;
                            2'd1: sh_prescale_r <= cfg.wr_data[7:0];
                            2'd2: begin
                                sh_en_r        <= cfg.wr_data[0];
                                sh_upnotdown_r <= cfg.wr_data[1];
                            end
                            2'd3: count_reset_r <= 1'b1;
                            default: count_reset_r <= 1'b0;
                        endcase
                    end else begin
                        count_reset_r <= 1'b0;
                    end
                    // A same-cycle write lands in the shadow first, so the commit picks it up
                    if (cfg.commit_req) begin
                        state_r <= ST_ARMED;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    if (safe_s) begin
                        period_r      <= sh_period_r;
                        prescale_r    <= sh_prescale_r;
                        en_r          <= sh_en_r;
                        upnotdown_r   <= sh_upnotdown_r;
                        count_reset_r <= 1'b1;
                        commit_done_r <= 1'b1;
                        state_r       <= ST_APPLY;
                    end else begin
                        state_r <= ST_ARMED;
                    end
                end
                ST_APPLY: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
